wb_arbitrated_stage: RTL and testbench
======================================

// Module: wb_arbitrated_stage
// PURPOSE
//  Parametrised writeback stage. Registers MEM-stage results, formats loads (sign/zero extend,
//  byte-offset aligned), and arbitrates the single register-file write port between the in-order
//  MEM pipeline and out-of-band multi-cycle MUL/DIV completions, buffered in a small FIFO.
//  Sits between the MEM/WB boundary and the register file; feeds the hazard unit a stall request.
// PARAMETERS
//  XLEN          32  datapath width
//  REG_ADDR_W    5   register index width
//  BUF_DEPTH     4   MUL/DIV result FIFO entries; power of 2, >=2
//  STARVE_LIMIT  8   consecutive cycles a non-empty FIFO head may wait before WB_STALL_REQ
// PORTS
//  CLK                  in   1           clock, rising edge
//  RST_N                in   1           synchronous reset, active-low
//  MEM_VALID            in   1           MEM-stage slot holds a real instruction
//  MEM_WRITE_ENABLE     in   1           instruction writes rd
//  MEM_DATA_MEM_SELECT  in   1           1: load data, 0: MEM_JAL_SELECTED
//  MEM_FUNC3            in   3           load type (LB/LH/LW/LBU/LHU)
//  MEM_BYTE_OFFSET      in   2           address[1:0] of the load
//  MEM_JAL_SELECTED     in   XLEN        ALU / PC+4 result
//  MEM_DATA_OUT         in   XLEN        raw aligned memory word
//  MEM_RD               in   REG_ADDR_W  destination
//  MD_VALID             in   1           MUL/DIV result offered
//  MD_RD                in   REG_ADDR_W  MUL/DIV destination
//  MD_DATA              in   XLEN        MUL/DIV result
//  MD_READY             out  1           result accepted when MD_VALID & MD_READY
//  WB_STALL_REQ         out  1           hazard unit must hold MEM/WB register this cycle
//  WB_WRITE_ENABLE      out  1           register-file write strobe
//  WB_WRITE_DATA        out  XLEN        write data
//  WB_RD                out  REG_ADDR_W  write index
// BEHAVIOUR
//  - Reset (RST_N=0 at edge): WB_* = 0, FIFO empty, starve counter 0; MD_READY=0 and
//    WB_STALL_REQ=0 while RST_N=0. Reset mid-operation discards buffered results.
//  - Latency: selected source appears on WB_* one cycle after the edge it is sampled on.
//  - Load format (MEM_DATA_MEM_SELECT=1): 000 LB sext byte[offset]; 001 LH sext half[offset[1]];
//    010 LW word; 100 LBU zext byte; 101 LHU zext half; other func3 pass word unchanged.
//  - mem_req = MEM_VALID & MEM_WRITE_ENABLE & (MEM_RD!=0). rd=0 never produces a write.
//  - Priority per cycle: (1) WB_STALL_REQ=1 -> pop FIFO head, MEM inputs ignored (held upstream);
//    (2) mem_req -> MEM wins; (3) FIFO non-empty -> pop head; (4) FIFO empty & MD_VALID -> bypass
//    MD directly to WB_* (no push); (5) else WB_WRITE_ENABLE=0.
//  - MD_READY = (count < BUF_DEPTH); no same-cycle pop credit. Accepted MD not bypassed is pushed.
//    Push and pop in one cycle: count unchanged. MD_RD=0 accepted and dropped.
//  - Pointers wrap modulo BUF_DEPTH; count width $clog2(BUF_DEPTH+1).
//  - Starve counter: +1 each cycle FIFO non-empty and no pop; cleared on pop or empty; saturates.
//    WB_STALL_REQ = (counter == STARVE_LIMIT) & non-empty; drops the cycle after the pop.
//  - WAW/RAW ordering between MEM and MD results is the scoreboard's responsibility, not this block.
// STRUCTURE
//  - Package wb_pkg: load func3 constants (LB/LH/LW/LBU/LHU), load_format() function, XLEN default.
//  - Sub-module wb_result_fifo (DEPTH, WIDTH=XLEN+REG_ADDR_W): push/pop/full/empty/count.
//  - Top: arbitration mux, starve counter, output register.
// TESTING
//  - LB: func3=000, offset=2, DATA_OUT=32'h0080_00FA, rd=2 -> next cycle WE=1, RD=2, DATA=32'hFFFF_FF80.
//  - LHU: func3=101, offset=2, DATA_OUT=32'hFAFF_0F00, rd=5 -> DATA=32'h0000_FAFF.
//  - rd=0 with WRITE_ENABLE=1 -> WB_WRITE_ENABLE=0; idle FIFO & MD_VALID (rd=7, 32'hCAFEBABE) -> bypass next cycle.
//  - Continuous mem_req, push 5 MD results, DEPTH=4 -> MD_READY=0 after 4th; count stays 4.
//  - Head waits 8 cycles under mem_req -> WB_STALL_REQ=1; head written next cycle; REQ low after.
//  - RST_N=0 with 3 buffered entries -> all WB_* 0, FIFO empty, no buffered write after release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: load func3 encodings, result source
// selection and the load formatting function.
package wb_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_STALL_POP,
        SRC_MEM,
        SRC_FIFO,
        SRC_BYPASS
    } wbSrc_e;

    // Picks the addressed byte/half out of the raw word and extends it; unknown func3 passes through.
    function automatic logic [XLEN_DEFAULT-1:0] load_format(
        input logic [2:0]              func3,
        input logic [1:0]              offset,
        input logic [XLEN_DEFAULT-1:0] word
    );
        logic [7:0]              byteSel;
        logic [15:0]             halfSel;
        logic [XLEN_DEFAULT-1:0] result;
        byteSel = word[{offset, 3'b000} +: 8];
        halfSel = offset[1] ? word[31:16] : word[15:0];
        case (func3)
            F3_LB:   result = {{(XLEN_DEFAULT-8){byteSel[7]}}, byteSel};
            F3_LH:   result = {{(XLEN_DEFAULT-16){halfSel[15]}}, halfSel};
            F3_LW:   result = word;
            F3_LBU:  result = {{(XLEN_DEFAULT-8){1'b0}}, byteSel};
            F3_LHU:  result = {{(XLEN_DEFAULT-16){1'b0}}, halfSel};
            default: result = word;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Small circular buffer holding out-of-band MUL/DIV results ({rd, data}) until the
// register-file write port is free.
module wb_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             pushData_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             headData_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             doPush;
    logic             doPop;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign headData_o = mem_q[rdPtr_q];
    assign doPush     = push_i & ~full_o;
    assign doPop      = pop_i & ~empty_o;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

endmodule

// File: rtl/wb_arbitrated_stage.sv
// Writeback stage: formats MEM-stage loads and shares the register-file write port between
// the in-order pipeline and buffered MUL/DIV completions, with starvation protection.
module wb_arbitrated_stage
    import wb_pkg::*;
#(
    parameter int XLEN         = XLEN_DEFAULT,
    parameter int REG_ADDR_W   = 5,
    parameter int BUF_DEPTH    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  mem_valid_i,
    input  logic                  mem_write_enable_i,
    input  logic                  mem_data_mem_select_i,
    input  logic [2:0]            mem_func3_i,
    input  logic [1:0]            mem_byte_offset_i,
    input  logic [XLEN-1:0]       mem_jal_selected_i,
    input  logic [XLEN-1:0]       mem_data_out_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  md_valid_i,
    input  logic [REG_ADDR_W-1:0] md_rd_i,
    input  logic [XLEN-1:0]       md_data_i,
    output logic                  md_ready_o,
    output logic                  wb_stall_req_o,
    output logic                  wb_write_enable_o,
    output logic [XLEN-1:0]       wb_write_data_o,
    output logic [REG_ADDR_W-1:0] wb_rd_o
);

    localparam int ENTRY_W  = XLEN + REG_ADDR_W;
    localparam int CNT_W    = $clog2(BUF_DEPTH + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]    DEPTH_C    = CNT_W'(BUF_DEPTH);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic                  memReq;
    logic                  mdAccept;
    logic                  stallReq;
    logic                  mdReady;
    logic [XLEN-1:0]       memResult;
    wbSrc_e                src;

    logic                  fifoPush;
    logic                  fifoPop;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic [CNT_W-1:0]      fifoCount;
    logic [ENTRY_W-1:0]    fifoHead;
    logic [REG_ADDR_W-1:0] headRd;
    logic [XLEN-1:0]       headData;

    logic [STARVE_W-1:0]   starveCnt_q, starveCnt_d;
    logic                  wbWe_q, wbWe_d;
    logic [XLEN-1:0]       wbData_q, wbData_d;
    logic [REG_ADDR_W-1:0] wbRd_q, wbRd_d;

    assign memReq    = mem_valid_i & mem_write_enable_i & (mem_rd_i != '0);
    assign memResult = mem_data_mem_select_i
                     ? load_format(mem_func3_i, mem_byte_offset_i, mem_data_out_i)
                     : mem_jal_selected_i;
    assign {headRd, headData} = fifoHead;

    // Handshake and stall are forced low while reset is asserted.
    assign mdReady  = rst_ni & (fifoCount < DEPTH_C);
    assign stallReq = rst_ni & ~fifoEmpty & (starveCnt_q == STARVE_MAX);
    assign mdAccept = md_valid_i & mdReady;

    always_comb begin
        src = SRC_NONE;
        if (stallReq) begin
            src = SRC_STALL_POP;
        end else if (memReq) begin
            src = SRC_MEM;
        end else if (!fifoEmpty) begin
            src = SRC_FIFO;
        end else if (mdAccept) begin
            src = SRC_BYPASS;
        end
    end

    always_comb begin
        wbWe_d   = 1'b0;
        wbData_d = '0;
        wbRd_d   = '0;
        case (src)
            SRC_STALL_POP, SRC_FIFO: begin
                wbWe_d   = 1'b1;
                wbData_d = headData;
                wbRd_d   = headRd;
            end
            SRC_MEM: begin
                wbWe_d   = 1'b1;
                wbData_d = memResult;
                wbRd_d   = mem_rd_i;
            end
            SRC_BYPASS: begin
                if (md_rd_i != '0) begin
                    wbWe_d   = 1'b1;
                    wbData_d = md_data_i;
                    wbRd_d   = md_rd_i;
                end
            end
            default: begin
                wbWe_d = 1'b0;
            end
        endcase
    end

    // A result to x0 is accepted but never stored.
    assign fifoPop  = (src == SRC_STALL_POP) | (src == SRC_FIFO);
    assign fifoPush = mdAccept & (src != SRC_BYPASS) & (md_rd_i != '0) & ~fifoFull;

    always_comb begin
        starveCnt_d = starveCnt_q;
        if (fifoEmpty || fifoPop) begin
            starveCnt_d = '0;
        end else if (starveCnt_q != STARVE_MAX) begin
            starveCnt_d = starveCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            starveCnt_q <= '0;
            wbWe_q      <= 1'b0;
            wbData_q    <= '0;
            wbRd_q      <= '0;
        end else begin
            starveCnt_q <= starveCnt_d;
            wbWe_q      <= wbWe_d;
            wbData_q    <= wbData_d;
            wbRd_q      <= wbRd_d;
        end
    end

    wb_result_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (fifoPush),
        .pushData_i ({md_rd_i, md_data_i}),
        .pop_i      (fifoPop),
        .headData_o (fifoHead),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty),
        .count_o    (fifoCount)
    );

    assign md_ready_o        = mdReady;
    assign wb_stall_req_o    = stallReq;
    assign wb_write_enable_o = wbWe_q;
    assign wb_write_data_o   = wbData_q;
    assign wb_rd_o           = wbRd_q;

endmodule

// File: tb/tb_wb_arbitrated_stage.sv
// Directed bench for wb_arbitrated_stage: load formatting, rd=0 filtering, MD bypass,
// FIFO back-pressure, starvation stall and mid-operation reset.
module tb_wb_arbitrated_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        mem_valid_i;
    logic        mem_write_enable_i;
    logic        mem_data_mem_select_i;
    logic [2:0]  mem_func3_i;
    logic [1:0]  mem_byte_offset_i;
    logic [31:0] mem_jal_selected_i;
    logic [31:0] mem_data_out_i;
    logic [4:0]  mem_rd_i;
    logic        md_valid_i;
    logic [4:0]  md_rd_i;
    logic [31:0] md_data_i;
    logic        md_ready_o;
    logic        wb_stall_req_o;
    logic        wb_write_enable_o;
    logic [31:0] wb_write_data_o;
    logic [4:0]  wb_rd_o;

    int total = 0;
    int bad   = 0;

    localparam int NLD = 7;
    localparam logic [2:0]  LD_F3  [NLD] = '{3'b000, 3'b101, 3'b001, 3'b001, 3'b010, 3'b100, 3'b011};
    localparam logic [1:0]  LD_OFF [NLD] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd1, 2'd3, 2'd0};
    localparam logic [31:0] LD_WORD[NLD] = '{32'h0080_00FA, 32'hFAFF_0F00, 32'h8001_1234, 32'h8001_1234,
                                             32'hDEAD_BEEF, 32'hAB00_0000, 32'h1234_5678};
    localparam logic [31:0] LD_EXP [NLD] = '{32'hFFFF_FF80, 32'h0000_FAFF, 32'hFFFF_8001, 32'h0000_1234,
                                             32'hDEAD_BEEF, 32'h0000_00AB, 32'h1234_5678};
    localparam logic [4:0]  LD_RD  [NLD] = '{5'd2, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10};

    wb_arbitrated_stage dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .mem_valid_i           (mem_valid_i),
        .mem_write_enable_i    (mem_write_enable_i),
        .mem_data_mem_select_i (mem_data_mem_select_i),
        .mem_func3_i           (mem_func3_i),
        .mem_byte_offset_i     (mem_byte_offset_i),
        .mem_jal_selected_i    (mem_jal_selected_i),
        .mem_data_out_i        (mem_data_out_i),
        .mem_rd_i              (mem_rd_i),
        .md_valid_i            (md_valid_i),
        .md_rd_i               (md_rd_i),
        .md_data_i             (md_data_i),
        .md_ready_o            (md_ready_o),
        .wb_stall_req_o        (wb_stall_req_o),
        .wb_write_enable_o     (wb_write_enable_o),
        .wb_write_data_o       (wb_write_data_o),
        .wb_rd_o               (wb_rd_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic setIdle();
        mem_valid_i           = 1'b0;
        mem_write_enable_i    = 1'b0;
        mem_data_mem_select_i = 1'b0;
        mem_func3_i           = 3'b000;
        mem_byte_offset_i     = 2'd0;
        mem_jal_selected_i    = 32'h0;
        mem_data_out_i        = 32'h0;
        mem_rd_i              = 5'd0;
        md_valid_i            = 1'b0;
        md_rd_i               = 5'd0;
        md_data_i             = 32'h0;
    endtask

    task automatic driveJal(input logic [4:0] rd, input logic [31:0] value);
        mem_valid_i           = 1'b1;
        mem_write_enable_i    = 1'b1;
        mem_data_mem_select_i = 1'b0;
        mem_jal_selected_i    = value;
        mem_data_out_i        = 32'h5555_5555;
        mem_rd_i              = rd;
    endtask

    task automatic test_reset();
        setIdle();
        rst_ni = 1'b0;
        tick();
        tick();
        total++; if (wb_write_enable_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_we: got %b want 0", wb_write_enable_o); end
        total++; if (wb_write_data_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_data: got %h want 0", wb_write_data_o); end
        total++; if (wb_rd_o !== 5'd0) begin bad++; $display("[TB] FAIL reset_rd: got %0d want 0", wb_rd_o); end
        total++; if (md_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_md_ready: got %b want 0", md_ready_o); end
        total++; if (wb_stall_req_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall: got %b want 0", wb_stall_req_o); end
        rst_ni = 1'b1;
        tick();
        total++; if (md_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_md_ready: got %b want 1", md_ready_o); end
        total++; if (wb_write_enable_o !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_we: got %b want 0", wb_write_enable_o); end
    endtask

    task automatic test_load_formats();
        for (int i = 0; i < NLD; i++) begin
            setIdle();
            mem_valid_i           = 1'b1;
            mem_write_enable_i    = 1'b1;
            mem_data_mem_select_i = 1'b1;
            mem_func3_i           = LD_F3[i];
            mem_byte_offset_i     = LD_OFF[i];
            mem_data_out_i        = LD_WORD[i];
            mem_jal_selected_i    = 32'h7777_7777;
            mem_rd_i              = LD_RD[i];
            tick();
            total++; if (wb_write_enable_o !== 1'b1) begin bad++; $display("[TB] FAIL load%0d_we: got %b want 1", i, wb_write_enable_o); end
            total++; if (wb_rd_o !== LD_RD[i]) begin bad++; $display("[TB] FAIL load%0d_rd: got %0d want %0d", i, wb_rd_o, LD_RD[i]); end
            total++; if (wb_write_data_o !== LD_EXP[i]) begin bad++; $display("[TB] FAIL load%0d_data: got %h want %h", i, wb_write_data_o, LD_EXP[i]); end
        end
        setIdle();
        driveJal(5'd31, 32'h0000_4004);
        tick();
        total++; if (wb_write_data_o !== 32'h0000_4004) begin bad++; $display("[TB] FAIL jal_data: got %h want 00004004", wb_write_data_o); end
        total++; if (wb_rd_o !== 5'd31) begin bad++; $display("[TB] FAIL jal_rd: got %0d want 31", wb_rd_o); end
        setIdle();
        tick();
    endtask

    task automatic test_rd_zero_and_bypass();
        setIdle();
        driveJal(5'd0, 32'h1111_1111);
        tick();
        total++; if (wb_write_enable_o !== 1'b0) begin bad++; $display("[TB] FAIL mem_rd0_we: got %b want 0", wb_write_enable_o); end
        driveJal(5'd3, 32'h3333_3333);
        md_valid_i = 1'b1; md_rd_i = 5'd0; md_data_i = 32'h9999_9999;
        total++; if (md_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL md_rd0_ready: got %b want 1", md_ready_o); end
        tick();
        total++; if (wb_rd_o !== 5'd3 || wb_write_data_o !== 32'h3333_3333) begin bad++; $display("[TB] FAIL mem_over_md: got rd=%0d data=%h want rd=3 data=33333333", wb_rd_o, wb_write_data_o); end
        setIdle();
        tick();
        total++; if (wb_write_enable_o !== 1'b0) begin bad++; $display("[TB] FAIL md_rd0_dropped: got we=%b want 0", wb_write_enable_o); end
        md_valid_i = 1'b1; md_rd_i = 5'd0; md_data_i = 32'h8888_8888;
        tick();
        total++; if (wb_write_enable_o !== 1'b0) begin bad++; $display("[TB] FAIL bypass_rd0_we: got %b want 0", wb_write_enable_o); end
        md_valid_i = 1'b1; md_rd_i = 5'd7; md_data_i = 32'hCAFE_BABE;
        tick();
        total++; if (wb_write_enable_o !== 1'b1 || wb_rd_o !== 5'd7 || wb_write_data_o !== 32'hCAFE_BABE)
            begin bad++; $display("[TB] FAIL bypass: got we=%b rd=%0d data=%h want we=1 rd=7 data=cafebabe", wb_write_enable_o, wb_rd_o, wb_write_data_o); end
        setIdle();
        tick();
        total++; if (wb_write_enable_o !== 1'b0) begin bad++; $display("[TB] FAIL bypass_not_pushed: got we=%b want 0", wb_write_enable_o); end
    endtask

    // Cycles 0..8: MEM writes every cycle while MD offers five results; the FIFO fills after four.
    task automatic test_fifo_full();
        logic [31:0] expJal;
        int          idx;
        setIdle();
        for (int c = 0; c < 9; c++) begin
            expJal = 32'h0000_1000 + 32'(c);
            idx    = (c < 4) ? c : 4;
            driveJal(5'd1, expJal);
            md_valid_i = 1'b1;
            md_rd_i    = 5'(10 + idx);
            md_data_i  = 32'hD000_0000 + 32'(idx);
            if (c < 4) begin
                total++; if (md_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL fill_ready_c%0d: got %b want 1", c, md_ready_o); end
            end else begin
                total++; if (md_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL full_ready_c%0d: got %b want 0", c, md_ready_o); end
                total++; if (wb_stall_req_o !== 1'b0) begin bad++; $display("[TB] FAIL early_stall_c%0d: got %b want 0", c, wb_stall_req_o); end
            end
            tick();
            total++; if (wb_write_enable_o !== 1'b1 || wb_rd_o !== 5'd1 || wb_write_data_o !== expJal)
                begin bad++; $display("[TB] FAIL fill_mem_c%0d: got we=%b rd=%0d data=%h want we=1 rd=1 data=%h", c, wb_write_enable_o, wb_rd_o, wb_write_data_o, expJal); end
        end
    endtask

    task automatic test_starve();
        driveJal(5'd1, 32'h0000_1009);
        md_valid_i = 1'b1; md_rd_i = 5'd14; md_data_i = 32'hD000_0004;
        total++; if (wb_stall_req_o !== 1'b1) begin bad++; $display("[TB] FAIL starve_stall: got %b want 1", wb_stall_req_o); end
        total++; if (md_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL starve_ready: got %b want 0", md_ready_o); end
        tick();
        total++; if (wb_write_enable_o !== 1'b1 || wb_rd_o !== 5'd10 || wb_write_data_o !== 32'hD000_0000)
            begin bad++; $display("[TB] FAIL starve_head: got we=%b rd=%0d data=%h want we=1 rd=10 data=d0000000", wb_write_enable_o, wb_rd_o, wb_write_data_o); end
        driveJal(5'd1, 32'h0000_100A);
        total++; if (wb_stall_req_o !== 1'b0) begin bad++; $display("[TB] FAIL stall_drop: got %b want 0", wb_stall_req_o); end
        total++; if (md_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL ready_after_pop: got %b want 1", md_ready_o); end
        tick();
        total++; if (wb_rd_o !== 5'd1 || wb_write_data_o !== 32'h0000_100A) begin bad++; $display("[TB] FAIL mem_after_stall: got rd=%0d data=%h want rd=1 data=0000100a", wb_rd_o, wb_write_data_o); end
        setIdle();
        for (int j = 1; j <= 4; j++) begin
            tick();
            total++; if (wb_write_enable_o !== 1'b1 || wb_rd_o !== 5'(10 + j) || wb_write_data_o !== 32'hD000_0000 + 32'(j))
                begin bad++; $display("[TB] FAIL drain%0d: got we=%b rd=%0d data=%h want rd=%0d", j, wb_write_enable_o, wb_rd_o, wb_write_data_o, 10 + j); end
        end
        tick();
        total++; if (wb_write_enable_o !== 1'b0) begin bad++; $display("[TB] FAIL drain_empty: got we=%b want 0", wb_write_enable_o); end
    endtask

    task automatic test_reset_mid();
        setIdle();
        for (int c = 0; c < 3; c++) begin
            driveJal(5'd4, 32'h0000_2000 + 32'(c));
            md_valid_i = 1'b1;
            md_rd_i    = 5'(20 + c);
            md_data_i  = 32'hE000_0000 + 32'(c);
            tick();
        end
        setIdle();
        total++; if (md_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL three_buffered_ready: got %b want 1", md_ready_o); end
        rst_ni = 1'b0;
        tick();
        total++; if (wb_write_enable_o !== 1'b0 || wb_write_data_o !== 32'h0 || wb_rd_o !== 5'd0)
            begin bad++; $display("[TB] FAIL midreset_wb: got we=%b rd=%0d data=%h want all 0", wb_write_enable_o, wb_rd_o, wb_write_data_o); end
        total++; if (md_ready_o !== 1'b0 || wb_stall_req_o !== 1'b0) begin bad++; $display("[TB] FAIL midreset_hs: got ready=%b stall=%b want 0 0", md_ready_o, wb_stall_req_o); end
        rst_ni = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (wb_write_enable_o !== 1'b0) begin bad++; $display("[TB] FAIL postreset_we%0d: got %b want 0", k, wb_write_enable_o); end
        end
    endtask

    initial begin
        setIdle();
        test_reset();
        test_load_formats();
        test_rd_zero_and_bypass();
        test_fifo_full();
        test_starve();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
